// File: rtl/oddr_clk_pattern_gen.sv
// ============================================================================
// oddr_clk_pattern_gen : D0/D1 pattern source for an ODDR2 forwarded clock,
// half-cycle resolution period/high time. Option: CLKGEN_PERIOD_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module oddr_clk_pattern_gen #(
   parameter int DIV_WIDTH = 8,
   parameter int DEF_DIV   = 2,
   parameter int DEF_HI    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   input  logic [DIV_WIDTH-1:0] cfg_hi,
   output logic                 cfg_err,
   output logic                 d0,
   output logic                 d1,
   output logic                 period_start,
`ifdef CLKGEN_PERIOD_CNT_EN
   output logic [15:0]          period_cnt,
`endif
   output logic                 running
);

   localparam int XW = DIV_WIDTH + 1;
   localparam logic [XW-1:0]        ONE_X   = XW'(1);
   localparam logic [XW-1:0]        TWO_X   = XW'(2);
   localparam logic [XW-1:0]        ZERO_X  = '0;
   localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(DEF_DIV);
   localparam logic [DIV_WIDTH-1:0] RST_HI  = DIV_WIDTH'(DEF_HI);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] slot_q, slot_d;
   logic [DIV_WIDTH-1:0] act_div_q, act_div_d;
   logic [DIV_WIDTH-1:0] act_hi_q, act_hi_d;
   logic                 pend_q, pend_d;
   logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
   logic [DIV_WIDTH-1:0] pend_hi_q, pend_hi_d;
   logic                 d0_q, d0_d;
   logic                 d1_q, d1_d;
   logic                 ps_q, ps_d;
   logic                 running_q, running_d;
   logic                 cfg_err_q, cfg_err_d;
   logic                 cfg_ready_q, cfg_ready_d;
`ifdef CLKGEN_PERIOD_CNT_EN
   logic [15:0]          cnt_q, cnt_d;
`endif

   logic [XW-1:0] s_x, s1_x, nxt_x;
   logic [XW-1:0] p0_x, h0_x, p1_x, h1_x;
   logic [XW-1:0] cdiv_x, chi_x;
   logic          emit, stop, wrap1, use_pend0, use_pend1, xfer, legal;

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      act_div_d   = act_div_q;
      act_hi_d    = act_hi_q;
      pend_d      = pend_q;
      pend_div_d  = pend_div_q;
      pend_hi_d   = pend_hi_q;
      d0_d        = 1'b0;
      d1_d        = 1'b0;
      ps_d        = 1'b0;

      stop = ~enable;
      // A stopping line never sits on slot 0, so slot 0 without enable means idle.
      emit = enable | ((state_q != ST_IDLE) & (slot_q != '0));

      s_x       = {1'b0, slot_q};
      use_pend0 = pend_q & (slot_q == '0);
      p0_x      = use_pend0 ? {1'b0, pend_div_q} : {1'b0, act_div_q};
      h0_x      = use_pend0 ? {1'b0, pend_hi_q}  : {1'b0, act_hi_q};
      wrap1     = ((s_x + ONE_X) == p0_x);
      use_pend1 = pend_q & wrap1 & ~use_pend0;
      p1_x      = use_pend1 ? {1'b0, pend_div_q} : p0_x;
      h1_x      = use_pend1 ? {1'b0, pend_hi_q}  : h0_x;
      s1_x      = wrap1 ? ZERO_X : (s_x + ONE_X);
      nxt_x     = ((s1_x + ONE_X) == p1_x) ? ZERO_X : (s1_x + ONE_X);

      if (!emit) begin
         state_d = ST_IDLE;
         slot_d  = '0;
         if (pend_q) begin
            act_div_d = pend_div_q;
            act_hi_d  = pend_hi_q;
            pend_d    = 1'b0;
         end
      end else begin
         d0_d      = (s_x < h0_x);
         d1_d      = (s1_x < h1_x);
         ps_d      = (slot_q == '0) | wrap1;
         act_div_d = p1_x[DIV_WIDTH-1:0];
         act_hi_d  = h1_x[DIV_WIDTH-1:0];
         if (use_pend0 | use_pend1) begin
            pend_d = 1'b0;
         end
         if (wrap1 & stop) begin
            // Second half would open a new period: suppress it and stop here.
            d1_d    = 1'b0;
            ps_d    = (slot_q == '0);
            state_d = ST_IDLE;
            slot_d  = '0;
         end else if (stop & (nxt_x == ZERO_X)) begin
            state_d = ST_IDLE;
            slot_d  = '0;
         end else begin
            state_d = stop ? ST_STOPPING : ST_RUN;
            slot_d  = nxt_x[DIV_WIDTH-1:0];
         end
      end
      running_d = emit;

      cdiv_x    = {1'b0, cfg_div};
      chi_x     = {1'b0, cfg_hi};
      legal     = (cdiv_x >= TWO_X) & (chi_x != ZERO_X) & (chi_x < cdiv_x);
      xfer      = cfg_valid & cfg_ready_q;
      cfg_err_d = xfer & ~legal;
      if (xfer & legal) begin
         pend_d     = 1'b1;
         pend_div_d = cfg_div;
         pend_hi_d  = cfg_hi;
      end
      cfg_ready_d = ~pend_d;

`ifdef CLKGEN_PERIOD_CNT_EN
      cnt_d = cnt_q + {15'd0, ps_d};
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         slot_q      <= '0;
         act_div_q   <= RST_DIV;
         act_hi_q    <= RST_HI;
         pend_q      <= 1'b0;
         pend_div_q  <= '0;
         pend_hi_q   <= '0;
         d0_q        <= 1'b0;
         d1_q        <= 1'b0;
         ps_q        <= 1'b0;
         running_q   <= 1'b0;
         cfg_err_q   <= 1'b0;
         cfg_ready_q <= 1'b1;
`ifdef CLKGEN_PERIOD_CNT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         act_div_q   <= act_div_d;
         act_hi_q    <= act_hi_d;
         pend_q      <= pend_d;
         pend_div_q  <= pend_div_d;
         pend_hi_q   <= pend_hi_d;
         d0_q        <= d0_d;
         d1_q        <= d1_d;
         ps_q        <= ps_d;
         running_q   <= running_d;
         cfg_err_q   <= cfg_err_d;
         cfg_ready_q <= cfg_ready_d;
`ifdef CLKGEN_PERIOD_CNT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign d0           = d0_q;
   assign d1           = d1_q;
   assign period_start = ps_q;
   assign running      = running_q;
   assign cfg_err      = cfg_err_q;
   assign cfg_ready    = cfg_ready_q;
`ifdef CLKGEN_PERIOD_CNT_EN
   assign period_cnt   = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_oddr_clk_pattern_gen.sv
// ============================================================================
// tb_oddr_clk_pattern_gen : randomized bench against a half-slot stream model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_oddr_clk_pattern_gen;

   localparam int NCYC = 3000;
   localparam int MID  = 1500;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable, cfg_valid;
   logic [7:0] cfg_div, cfg_hi;
   logic       cfg_ready, cfg_err, d0, d1, period_start, running;
`ifdef CLKGEN_PERIOD_CNT_EN
   logic [15:0] period_cnt;
`endif

   oddr_clk_pattern_gen #(.DIV_WIDTH(8), .DEF_DIV(2), .DEF_HI(1)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_div(cfg_div), .cfg_hi(cfg_hi),
      .cfg_err(cfg_err), .d0(d0), .d1(d1), .period_start(period_start),
`ifdef CLKGEN_PERIOD_CNT_EN
      .period_cnt(period_cnt),
`endif
      .running(running)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: a stream of half-cycle slots; two are consumed per clock.
   int m_p, m_h, m_slot, m_cnt;
   bit m_pend;
   int m_pp, m_ph;
   bit e_d0, e_d1, e_ps, e_run, e_err, e_rdy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_legal(input int div, input int hi);
      return (div >= 2) && (hi >= 1) && (hi < div);
   endfunction

   task automatic model_reset();
      m_p = 2; m_h = 1; m_slot = 0; m_cnt = 0; m_pend = 0; m_pp = 0; m_ph = 0;
      e_d0 = 0; e_d1 = 0; e_ps = 0; e_run = 0; e_err = 0; e_rdy = 1;
   endtask

   task automatic take_pending();
      if (m_pend) begin
         m_p = m_pp; m_h = m_ph; m_pend = 0;
      end
   endtask

   task automatic model_step(input bit en, input bit vld, input int div, input int hi);
      bit lvl[2];
      bit xfer, emit, ps;
      xfer  = vld && !m_pend;
      e_err = xfer && !is_legal(div, hi);
      emit  = en || (m_slot != 0);
      ps    = 0;
      lvl[0] = 0; lvl[1] = 0;
      if (!emit) begin
         take_pending();
      end else begin
         for (int h = 0; h < 2; h++) begin
            if (m_slot == 0) take_pending();
            if (h == 1 && m_slot == 0 && !en) begin
               lvl[h] = 0;
            end else begin
               lvl[h] = (m_slot < m_h);
               if (m_slot == 0) ps = 1;
               m_slot = (m_slot + 1) % m_p;
            end
         end
      end
      e_d0 = lvl[0]; e_d1 = lvl[1]; e_ps = ps; e_run = emit;
      m_cnt = (m_cnt + (ps ? 1 : 0)) % 65536;
      if (xfer && is_legal(div, hi)) begin
         m_pend = 1; m_pp = div; m_ph = hi;
      end
      e_rdy = !m_pend;
   endtask

   task automatic compare_all();
      check("d0", d0, e_d0);
      check("d1", d1, e_d1);
      check("period_start", period_start, e_ps);
      check("running", running, e_run);
      check("cfg_err", cfg_err, e_err);
      check("cfg_ready", cfg_ready, e_rdy);
`ifdef CLKGEN_PERIOD_CNT_EN
      check("period_cnt", period_cnt, m_cnt);
`endif
   endtask

   task automatic drive(input int c);
      int r, p, h;
      if (c < 20 || (c >= MID - 20 && c <= MID)) enable = 1'b1;
      else if ($urandom_range(0, 24) == 0) enable = ~enable;
      cfg_valid = (c >= 20) && ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 9);
      p = $urandom_range(2, 9);
      h = $urandom_range(1, p - 1);
      if (r == 7) h = ($urandom_range(0, 1) == 0) ? 0 : p + $urandom_range(0, 2);
      else if (r == 8) p = $urandom_range(0, 1);
      else if (r == 9) begin
         p = $urandom_range(10, 40);
         h = $urandom_range(1, p - 1);
      end
      cfg_div = 8'(p);
      cfg_hi  = 8'(h);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_hi = '0;
      model_reset();
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;
      for (int c = 0; c < NCYC; c++) begin
         drive(c);
         model_step(enable, cfg_valid, int'(cfg_div), int'(cfg_hi));
         @(negedge clk);
         compare_all();
         if (c == MID) begin
            rst_n = 1'b0;
            #1;
            check("async_rst_d0", d0, 0);
            check("async_rst_d1", d1, 0);
            check("async_rst_ps", period_start, 0);
            check("async_rst_running", running, 0);
`ifdef CLKGEN_PERIOD_CNT_EN
            check("async_rst_cnt", period_cnt, 0);
`endif
            model_reset();
            @(negedge clk);
            compare_all();
            rst_n = 1'b1;
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/oddr_clk_pattern_gen.md
Name: oddr_clk_pattern_gen

Overview:
- Generates the D0/D1 data pair for an ODDR2 clock-forwarding output.
- Produces a divided clock with programmable period and high time at half-cycle resolution from a single fast clock (e.g. the 300 MHz clock-manager output).
- Sits directly upstream of the ODDR2 primitive: d0 goes to ODDR2.D0 (C0 edge) and d1 goes to ODDR2.D1 (C1 edge).
- Config changes are glitch-free and take effect only at a period boundary.

Parameters:
- DIV_WIDTH, 8, width of period/high-time fields, in half-cycle units.
- DEF_DIV, 2, period loaded at reset (half-cycles).
- DEF_HI, 1, high time loaded at reset (half-cycles).

Ports:
- clk  input  1  fast clock; everything is synchronous to its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- enable  input  1  run request; level-sensitive.
- cfg_valid  input  1  new config offered.
- cfg_ready  output  1  block can accept a config.
- cfg_div  input  DIV_WIDTH  period P in half-cycles; legal range 2..2^DIV_WIDTH-1.
- cfg_hi  input  DIV_WIDTH  high time H in half-cycles; legal range 1..P-1.
- cfg_err  output  1  one-cycle pulse when an offered config is rejected.
- d0  output  1  level for the first half of the cycle (to ODDR2.D0).
- d1  output  1  level for the second half of the cycle (to ODDR2.D1).
- period_start  output  1  asserted in any cycle where d0 or d1 carries slot 0.
- running  output  1  high while in RUN or STOPPING.

Behaviour:
- Reset values (all registered outputs): d0=0, d1=0, period_start=0, running=0, cfg_err=0, cfg_ready=1. Active config = DEF_DIV/DEF_HI. Slot counter = 0. State = IDLE.
- Slots: each clk cycle emits two half-cycle slots.
  - d0 = (slot s < H); d1 = (slot s' < H'), where s' = s+1, or 0 if s+1 = P.
  - The counter then advances to the next slot after s', wrapping modulo P.
  - Outputs are registered: 1 cycle latency from counter state to d0/d1.
- Odd P is legal. The period boundary can then fall mid-cycle.
  - If s' wraps to 0, s' is evaluated with the pending config if one is pending; that config becomes active on the same edge.
  - So a new config always starts exactly at slot 0.
- State machine:
  - IDLE: d0=d1=0, counter held at 0. enable=1 -> RUN; the first output cycle carries slot 0 (period_start=1).
  - RUN: pattern generated continuously. enable=0 -> STOPPING.
  - STOPPING: the current period completes. When the next slot would be 0, go to IDLE and drive outputs 0. If enable returns to 1 before then, go back to RUN with no disturbance.
  - If the wrap occurs on s', d1 is forced 0 for that cycle. The line never emits a partial new period.
- Config handshake:
  - A transfer occurs when cfg_valid & cfg_ready.
  - Legal config: stored as pending; cfg_ready=0 until the pending config is activated. In IDLE it activates the next cycle; in RUN/STOPPING it activates at the next period boundary.
  - Illegal config (P<2, H=0, or H>=P): not stored; cfg_err pulses 1 cycle later; cfg_ready stays 1.
  - cfg_valid held high while cfg_ready=0 has no effect.
- Simultaneous events:
  - Config activation and a STOPPING->IDLE transition on the same edge: config becomes active, state goes to IDLE.
  - enable falling and cfg transfer on the same cycle: both are honoured.
- Reset mid-operation: outputs go low immediately (asynchronous); the pending config is discarded.
- All comparisons are unsigned, DIV_WIDTH+1 bits internally so s+1 and s+2 cannot overflow.

Optional Feature:
- Macro: CLKGEN_PERIOD_CNT_EN.
- Defined: adds output period_cnt (16 bits, reset 0).
  - Increments on every period_start in RUN/STOPPING.
  - Wraps from 0xFFFF to 0.
  - Holds its value in IDLE.
- Undefined: no port and no counter logic.

Test Plan:
- Reset defaults (P=2, H=1), enable=1 -> steady (d0,d1)=(1,0) every cycle; period_start=1 every cycle.
- Load P=4, H=2 while IDLE, enable=1 -> repeating (1,1),(0,0); period_start on alternate cycles.
- Load P=3, H=1 -> repeating (1,0),(0,1),(0,0); period_start in the first two cycles of each 3-cycle group.
- While running P=4/H=2, load P=6/H=3 mid-period -> switch occurs only at slot 0; cfg_ready low until then; no glitch.
- Offer cfg_div=4, cfg_hi=4 -> cfg_err pulses once; active config unchanged; cfg_ready stays 1.
- P=5/H=2 running, drop enable mid-period -> remaining slots of the period emitted; then d0=d1=0 and running=0. Assert rst_n=0 mid-period -> outputs 0 asynchronously; period_cnt=0 when CLKGEN_PERIOD_CNT_EN is defined.
